mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the polirv instruction-fetch side and its load/store side.
- Arbitrates requests, sequences memory wait states, and returns read data or a write acknowledgment to the winning requester.
- Data side has priority; a streak limit guarantees instruction fetch cannot starve.
- Sits between polirv's i_mem/d_mem interfaces and the shared memory macro.

Parameters:
- ADDR_BITS, 6, word address width of both requesters and the memory port.
- WORDSIZE, 64, memory and data-side word width.
- INSTRUCTION_SIZE, 32, instruction width returned to the fetch side.
- MEM_LATENCY, 1, number of BUSY cycles per access (>=1).
- MAX_D_STREAK, 4, consecutive data grants allowed while i_req is pending (>=1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_req  in  1  fetch request, held until i_gnt.
- i_addr  in  ADDR_BITS  fetch word address.
- i_gnt  out  1  fetch request accepted this cycle.
- i_rvalid  out  1  one-cycle pulse, i_rdata valid.
- i_rdata  out  INSTRUCTION_SIZE  mem word bits [INSTRUCTION_SIZE-1:0].
- d_req  in  1  data request, held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_BITS  data word address.
- d_wdata  in  WORDSIZE  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle pulse: load data valid or store committed.
- d_rdata  out  WORDSIZE  load data (0 after a store).
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_BITS  memory address.
- mem_wdata  out  WORDSIZE  memory write data.
- mem_rdata  in  WORDSIZE  memory read data, combinational from mem_addr.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values:
  - State IDLE; streak counter 0; latency counter 0.
  - All outputs 0: gnt, rvalid, rdata, mem_*, busy.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Gnt outputs are combinational from state and requests.
  - Winner selection:
    - If d_req and not (i_req and streak == MAX_D_STREAK), d wins.
    - Otherwise, if i_req, i wins.
  - Exactly one gnt is high in the grant cycle.
  - On the grant edge: latch the owner plus addr/we/wdata (fetch latches we=0, wdata=0); go to BUSY; latency counter = 0.
- Streak counter:
  - Increments (saturating at MAX_D_STREAK) on a d grant while i_req=1.
  - Clears on any i grant, or on a d grant while i_req=0.
- BUSY:
  - mem_en = 1; mem_addr, mem_we and mem_wdata driven from latched values; all held constant for all BUSY cycles.
  - Counter increments each cycle.
  - On the edge where counter == MEM_LATENCY-1: capture mem_rdata into the owner's rdata register and go to RESP.
  - Memory commits a write on that same edge.
  - Stores capture d_rdata = 0.
- RESP:
  - Owner's rvalid = 1 for exactly one cycle; mem_en = 0; mem_we = 0.
  - No grants in RESP; next state is IDLE.
- Timing:
  - Grant at cycle t.
  - BUSY occupies t+1 .. t+MEM_LATENCY.
  - rvalid at t+MEM_LATENCY+1.
  - Next grant no earlier than t+MEM_LATENCY+2.
- rdata registers hold their last value until overwritten by the next access of the same side.
- Requests arriving in BUSY/RESP are ignored until IDLE; requesters must hold req, addr and data stable until gnt.
- Dropping req before gnt withdraws the request with no side effect.
- Reset asserted mid-access:
  - Next cycle: IDLE, mem_en = 0, mem_we = 0.
  - No rvalid is issued for the aborted access.
  - Streak counter cleared; rdata registers cleared.

Test Plan:
- Single fetch, MEM_LATENCY=1, i_addr=5, mem[5]=0x00000013 -> i_gnt at t, mem_en/mem_addr=5 at t+1, i_rvalid with i_rdata=0x00000013 at t+2, busy 0 at t+3.
- Store then load, MEM_LATENCY=3: d_we=1, d_addr=9, d_wdata=0xDEADBEEFCAFEF00D -> mem_we=1 for 3 cycles, d_rvalid at t+4 with d_rdata=0. Then load addr 9 -> d_rdata=0xDEADBEEFCAFEF00D.
- Simultaneous i_req and d_req with streak 0 -> d_gnt, i_gnt=0. After that response, i_req still high and d_req low -> i_gnt at the next IDLE.
- Starvation guard, MAX_D_STREAK=4, i_req and d_req held high -> exactly 4 d grants, then 1 i grant, then 4 d grants, repeating.
- Reset pulsed during the 2nd BUSY cycle, MEM_LATENCY=3 -> next cycle mem_en=0, busy=0, no rvalid ever; a fresh request after reset completes normally.
- Request dropped before gnt while busy -> no grant issued, mem_en stays 0 once IDLE is reached.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the fetch side and the load/store side.
// Data side wins ties, and a streak limit on data grants guarantees fetch progress.
module mem_port_arbiter #(
   parameter int ADDR_BITS        = 6,
   parameter int WORDSIZE         = 64,
   parameter int INSTRUCTION_SIZE = 32,
   parameter int MEM_LATENCY      = 1,
   parameter int MAX_D_STREAK     = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_req,
   input  logic [ADDR_BITS-1:0]        i_addr,
   output logic                        i_gnt,
   output logic                        i_rvalid,
   output logic [INSTRUCTION_SIZE-1:0] i_rdata,
   input  logic                        d_req,
   input  logic                        d_we,
   input  logic [ADDR_BITS-1:0]        d_addr,
   input  logic [WORDSIZE-1:0]         d_wdata,
   output logic                        d_gnt,
   output logic                        d_rvalid,
   output logic [WORDSIZE-1:0]         d_rdata,
   output logic                        mem_en,
   output logic                        mem_we,
   output logic [ADDR_BITS-1:0]        mem_addr,
   output logic [WORDSIZE-1:0]         mem_wdata,
   input  logic [WORDSIZE-1:0]         mem_rdata,
   output logic                        busy
);

   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int STK_W = $clog2(MAX_D_STREAK + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);
   localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_D_STREAK);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                      state_q, state_d;
   logic                        owner_d_q, owner_d_d;
   logic [ADDR_BITS-1:0]        addr_q, addr_d;
   logic                        we_q, we_d;
   logic [WORDSIZE-1:0]         wdata_q, wdata_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [STK_W-1:0]            streak_q, streak_d;
   logic [INSTRUCTION_SIZE-1:0] i_rdata_q, i_rdata_d;
   logic [WORDSIZE-1:0]         d_rdata_q, d_rdata_d;
   logic                        i_win, d_win;

   // Data wins unless a waiting fetch has already been passed over MAX_D_STREAK times.
   always_comb begin
      i_win = 1'b0;
      d_win = 1'b0;
      if (state_q == IDLE) begin
         if (d_req && !(i_req && (streak_q == STK_MAX))) begin
            d_win = 1'b1;
         end else if (i_req) begin
            i_win = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d_d = owner_d_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      cnt_d     = cnt_q;
      streak_d  = streak_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      case (state_q)
         IDLE: begin
            if (d_win || i_win) begin
               state_d   = BUSY;
               owner_d_d = d_win;
               addr_d    = d_win ? d_addr : i_addr;
               we_d      = d_win & d_we;
               wdata_d   = d_win ? d_wdata : '0;
               cnt_d     = '0;
               if (i_win || !i_req) begin
                  streak_d = '0;
               end else if (streak_q != STK_MAX) begin
                  streak_d = streak_q + 1'b1;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = RESP;
               if (owner_d_q) begin
                  d_rdata_d = we_q ? '0 : mem_rdata;
               end else begin
                  i_rdata_d = mem_rdata[INSTRUCTION_SIZE-1:0];
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_d_q <= 1'b0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         cnt_q     <= '0;
         streak_q  <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_d_q <= owner_d_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         cnt_q     <= cnt_d;
         streak_q  <= streak_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   // Memory bus is zeroed outside BUSY so the macro only sees the latched access.
   assign i_gnt     = i_win;
   assign d_gnt     = d_win;
   assign mem_en    = (state_q == BUSY);
   assign mem_we    = mem_en & we_q;
   assign mem_addr  = mem_en ? addr_q : '0;
   assign mem_wdata = mem_en ? wdata_q : '0;
   assign i_rvalid  = (state_q == RESP) & ~owner_d_q;
   assign d_rvalid  = (state_q == RESP) & owner_d_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a latency-1 instance for the single-fetch timing check and a
// latency-3 instance driven by directed and random traffic against a transaction-level model.
module tb_mem_port_arbiter;
   localparam int AW   = 6;
   localparam int WS   = 64;
   localparam int IS   = 32;
   localparam int LAT  = 3;
   localparam int MAXS = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic          i_req, d_req, d_we, i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
   logic [AW-1:0] i_addr, d_addr, mem_addr;
   logic [WS-1:0] d_wdata, d_rdata, mem_wdata, mem_rdata;
   logic [IS-1:0] i_rdata;
   logic [WS-1:0] tb_mem [64];
   assign mem_rdata = tb_mem[mem_addr];

   logic          i_req_a, d_req_a, d_we_a, i_gnt_a, i_rvalid_a, d_gnt_a, d_rvalid_a;
   logic          mem_en_a, mem_we_a, busy_a;
   logic [AW-1:0] i_addr_a, d_addr_a, mem_addr_a;
   logic [WS-1:0] d_wdata_a, d_rdata_a, mem_wdata_a, mem_rdata_a;
   logic [IS-1:0] i_rdata_a;
   assign mem_rdata_a = (mem_addr_a == 6'd5) ? 64'h0000_0000_0000_0013 : 64'hBAD0_BAD0_BAD0_BAD0;

   mem_port_arbiter #(.ADDR_BITS(AW), .WORDSIZE(WS), .INSTRUCTION_SIZE(IS),
                      .MEM_LATENCY(LAT), .MAX_D_STREAK(MAXS)) u_dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy));

   mem_port_arbiter #(.ADDR_BITS(AW), .WORDSIZE(WS), .INSTRUCTION_SIZE(IS),
                      .MEM_LATENCY(1), .MAX_D_STREAK(MAXS)) u_dut_lat1 (
      .clk(clk), .rst(rst),
      .i_req(i_req_a), .i_addr(i_addr_a), .i_gnt(i_gnt_a), .i_rvalid(i_rvalid_a),
      .i_rdata(i_rdata_a),
      .d_req(d_req_a), .d_we(d_we_a), .d_addr(d_addr_a), .d_wdata(d_wdata_a), .d_gnt(d_gnt_a),
      .d_rvalid(d_rvalid_a), .d_rdata(d_rdata_a),
      .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
      .mem_rdata(mem_rdata_a), .busy(busy_a));

   int            n_checks, n_fail;
   int            m_left, m_streak;
   bit            m_own_d, m_we, seen_i, seen_d, log_on;
   logic [AW-1:0] m_addr;
   logic [WS-1:0] m_wdata, m_txn_data, m_i_last, m_d_last;
   logic [WS-1:0] ref_mem [64];
   byte           glog [$];

   function automatic logic [WS-1:0] init_word(input int k);
      return 64'hA5A5_0000_0000_0000 + 64'(k) * 64'h0001_0003_0005_0007;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock of the latency-3 instance: compare at the falling edge, then advance the model.
   task automatic tick();
      bit            ew_i, ew_d, s_en, s_we;
      logic [AW-1:0] s_addr;
      logic [WS-1:0] s_wd;
      @(negedge clk);
      ew_i = 1'b0;
      ew_d = 1'b0;
      if (m_left == 0) begin
         if (d_req && !(i_req && m_streak == MAXS)) ew_d = 1'b1;
         else if (i_req) ew_i = 1'b1;
      end
      chk("i_gnt", i_gnt, ew_i);
      chk("d_gnt", d_gnt, ew_d);
      chk("busy", busy, m_left != 0);
      chk("mem_en", mem_en, m_left >= 2);
      chk("mem_we", mem_we, m_left >= 2 && m_we);
      if (m_left >= 2) begin
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_wdata", mem_wdata, m_wdata);
      end
      chk("i_rvalid", i_rvalid, m_left == 1 && !m_own_d);
      chk("d_rvalid", d_rvalid, m_left == 1 && m_own_d);
      chk("i_rdata", i_rdata, m_i_last);
      chk("d_rdata", d_rdata, m_d_last);
      if (log_on && (i_gnt || d_gnt)) glog.push_back(d_gnt ? 8'd1 : 8'd0);
      s_en = mem_en; s_we = mem_we; s_addr = mem_addr; s_wd = mem_wdata;
      @(posedge clk);
      if (s_en && s_we) tb_mem[s_addr] = s_wd;
      if (rst) begin
         m_left = 0; m_streak = 0; m_i_last = '0; m_d_last = '0;
      end else if (ew_i || ew_d) begin
         m_own_d = ew_d;
         m_addr  = ew_d ? d_addr : i_addr;
         m_we    = ew_d && d_we;
         m_wdata = ew_d ? d_wdata : '0;
         if (m_we) begin
            ref_mem[m_addr] = d_wdata;
            m_txn_data = '0;
         end else begin
            m_txn_data = ref_mem[m_addr];
         end
         m_streak = (ew_d && i_req) ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
         m_left   = LAT + 1;
      end else if (m_left > 0) begin
         if (m_left == 2) begin
            if (m_own_d) m_d_last = m_txn_data;
            else m_i_last = {32'b0, m_txn_data[IS-1:0]};
         end
         m_left--;
      end
      seen_i = ew_i;
      seen_d = ew_d;
      #1;
   endtask

   task automatic wait_gnt(input bit side_d, input string tag);
      bit got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         tick();
         got = side_d ? seen_d : seen_i;
      end
      chk(tag, got, 1'b1);
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 20 && m_left != 0; k++) tick();
      chk("idle_reached", m_left == 0, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired observed=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WS-1:0] w;
      string         tg;
      n_checks = 0; n_fail = 0;
      rst = 1'b1;
      i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
      i_req_a = 0; d_req_a = 0; d_we_a = 0; i_addr_a = '0; d_addr_a = '0; d_wdata_a = '0;
      for (int k = 0; k < 64; k++) begin
         tb_mem[k]  = init_word(k);
         ref_mem[k] = init_word(k);
      end
      m_left = 0; m_streak = 0; m_i_last = '0; m_d_last = '0; m_own_d = 0; m_we = 0;
      m_addr = '0; m_wdata = '0; m_txn_data = '0; log_on = 0; seen_i = 0; seen_d = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Latency-1 instance: reset state, then a single fetch of address 5.
      @(negedge clk);
      chk("a_rst_busy", busy_a, 1'b0);
      chk("a_rst_mem_en", mem_en_a, 1'b0);
      chk("a_rst_mem_addr", mem_addr_a, '0);
      chk("a_rst_i_rdata", i_rdata_a, '0);
      chk("a_rst_d_rdata", d_rdata_a, '0);
      @(posedge clk);
      #1 i_req_a = 1'b1; i_addr_a = 6'd5;
      @(negedge clk);
      chk("a_i_gnt", i_gnt_a, 1'b1);
      chk("a_d_gnt", d_gnt_a, 1'b0);
      @(posedge clk);
      #1 i_req_a = 1'b0;
      @(negedge clk);
      chk("a_busy_mem_en", mem_en_a, 1'b1);
      chk("a_busy_mem_addr", mem_addr_a, 6'd5);
      chk("a_busy_mem_we", mem_we_a, 1'b0);
      chk("a_busy_rvalid", i_rvalid_a, 1'b0);
      @(negedge clk);
      chk("a_resp_rvalid", i_rvalid_a, 1'b1);
      chk("a_resp_rdata", i_rdata_a, 32'h0000_0013);
      chk("a_resp_mem_en", mem_en_a, 1'b0);
      @(negedge clk);
      chk("a_done_busy", busy_a, 1'b0);
      chk("a_done_rvalid", i_rvalid_a, 1'b0);
      chk("a_done_rdata_hold", i_rdata_a, 32'h0000_0013);
      @(posedge clk);
      #1;

      // Latency-3 instance: reset state.
      tick();
      tick();

      // Load 9, store 0xDEADBEEFCAFEF00D to 9, load it back.
      d_req = 1; d_we = 0; d_addr = 6'd9; d_wdata = 64'h1111_2222_3333_4444;
      wait_gnt(1'b1, "gnt_load9");
      d_req = 0;
      wait_idle();
      chk("load9_init", d_rdata, init_word(9));
      d_req = 1; d_we = 1; d_wdata = 64'hDEAD_BEEF_CAFE_F00D;
      wait_gnt(1'b1, "gnt_store9");
      d_req = 0; d_we = 0;
      wait_idle();
      chk("store_rdata_zero", d_rdata, '0);
      chk("store_committed", tb_mem[9], 64'hDEAD_BEEF_CAFE_F00D);
      d_req = 1;
      wait_gnt(1'b1, "gnt_reload9");
      d_req = 0;
      wait_idle();
      chk("reload9", d_rdata, 64'hDEAD_BEEF_CAFE_F00D);

      // Simultaneous requests with streak 0: data first, fetch at the next IDLE.
      i_req = 1; i_addr = 6'd3; d_req = 1; d_addr = 6'd7;
      tick();
      chk("sim_d_gnt_first", d_gnt === 1'b0 && seen_d, 1'b1);
      d_req = 0;
      wait_gnt(1'b0, "gnt_fetch_after_d");
      i_req = 0;
      wait_idle();
      w = init_word(3);
      chk("fetch3_data", i_rdata, {32'b0, w[IS-1:0]});

      // Starvation guard: both sides saturated.
      glog.delete();
      log_on = 1;
      i_req = 1; d_req = 1; d_we = 0;
      for (int k = 0; k < 200 && glog.size() < 15; k++) begin
         tick();
         if (seen_i) i_addr = AW'($urandom);
         if (seen_d) d_addr = AW'($urandom);
      end
      i_req = 0; d_req = 0; log_on = 0;
      wait_idle();
      chk("starve_grants", glog.size() >= 15, 1'b1);
      for (int k = 0; k < 15 && k < glog.size(); k++) begin
         tg = $sformatf("starve_seq%0d", k);
         chk(tg, glog[k], (k % 5 == 4) ? 8'd0 : 8'd1);
      end

      // Reset during the second BUSY cycle aborts the load silently.
      d_req = 1; d_we = 0; d_addr = 6'd12;
      wait_gnt(1'b1, "gnt_abort_load");
      d_req = 0;
      tick();
      rst = 1;
      tick();
      rst = 0;
      chk("abort_busy", busy, 1'b0);
      chk("abort_mem_en", mem_en, 1'b0);
      chk("abort_d_rdata", d_rdata, '0);
      repeat (6) tick();
      d_req = 1;
      wait_gnt(1'b1, "gnt_after_reset");
      d_req = 0;
      wait_idle();
      chk("after_reset_load", d_rdata, init_word(12));

      // Fetch request raised and withdrawn while the port is busy.
      d_req = 1; d_addr = 6'd20;
      wait_gnt(1'b1, "gnt_load20");
      d_req = 0;
      tick();
      i_req = 1; i_addr = 6'd1;
      tick();
      tick();
      i_req = 0;
      repeat (5) tick();
      chk("withdrawn_idle", busy, 1'b0);

      // Random traffic with withdrawals.
      for (int c = 0; c < 600; c++) begin
         if (seen_i || !i_req) begin
            i_req  = ($urandom_range(0, 2) != 0);
            i_addr = AW'($urandom);
         end else if ($urandom_range(0, 15) == 0) begin
            i_req = 0;
         end
         if (seen_d || !d_req) begin
            d_req   = ($urandom_range(0, 2) != 0);
            d_we    = $urandom_range(0, 1) == 1;
            d_addr  = AW'($urandom);
            d_wdata = {$urandom, $urandom};
         end else if ($urandom_range(0, 15) == 0) begin
            d_req = 0;
         end
         tick();
      end
      i_req = 0; d_req = 0;
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
